// File: rtl/led_pwm_fader.sv
// PWM afterglow driver: each pattern bit sets a per-LED level that decays linearly once the bit
// drops; levels are double-buffered per PWM frame and rendered as registered PWM outputs.
module led_pwm_fader #(
  parameter int unsigned N_LEDS     = 16,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DECAY_DIV  = 65536,
  parameter int unsigned DECAY_STEP = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_LEDS-1:0]   i_pattern,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [N_LEDS-1:0]   o_leds,
  output logic                o_frame
);

  localparam int unsigned PreW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] CntMax = {PWM_BITS{1'b1}};
  localparam logic [PreW-1:0] PreMax = PreW'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PreW-1:0]     r_pre;
  logic [PWM_BITS-1:0] r_lvl    [N_LEDS];
  logic [PWM_BITS-1:0] r_shadow [N_LEDS];

  logic                w_tick;
  logic                w_load;
  logic [PWM_BITS-1:0] w_cnt_next;
  logic [PreW-1:0]     w_pre_next;
  logic [PWM_BITS-1:0] w_lvl_next    [N_LEDS];
  logic [PWM_BITS-1:0] w_shadow_next [N_LEDS];
  logic [N_LEDS-1:0]   w_leds_next;

  always_comb begin
    w_tick     = (r_pre == PreMax);
    w_load     = (r_pwm_cnt == CntMax);
    w_cnt_next = r_pwm_cnt + 1'b1;
    w_pre_next = w_tick ? '0 : r_pre + 1'b1;
    w_leds_next = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      w_lvl_next[i]    = r_lvl[i];
      w_shadow_next[i] = w_load ? r_lvl[i] : r_shadow[i];
      if (i_pattern[i]) begin
        w_lvl_next[i] = i_brightness;
      end else if (w_tick) begin
        w_lvl_next[i] = (32'(r_lvl[i]) > DECAY_STEP) ? r_lvl[i] - PWM_BITS'(DECAY_STEP) : '0;
      end
      // Compare next-cycle counter/shadow so output slot 0 lands together with o_frame.
      w_leds_next[i] = (w_cnt_next < w_shadow_next[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_pre     <= '0;
      o_leds    <= '0;
      o_frame   <= 1'b0;
      for (int i = 0; i < int'(N_LEDS); i++) begin
        r_lvl[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      r_pwm_cnt <= w_cnt_next;
      r_pre     <= w_pre_next;
      o_leds    <= w_leds_next;
      o_frame   <= w_load;
      for (int i = 0; i < int'(N_LEDS); i++) begin
        r_lvl[i]    <= w_lvl_next[i];
        r_shadow[i] <= w_shadow_next[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: per-cycle reference model plus frame-duty checks.
module tb_led_pwm_fader;

  localparam int NLeds = 16;
  localparam int DecayDiv = 4;
  localparam int DecayStep = 64;
  localparam int Frame = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pat = '0;
  logic [7:0]  bri = '0;
  logic [15:0] leds;
  logic        frame;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .N_LEDS(16), .PWM_BITS(8), .DECAY_DIV(DecayDiv), .DECAY_STEP(DecayStep)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pattern(pat), .i_brightness(bri),
    .o_leds(leds), .o_frame(frame)
  );

  int checks = 0;
  int errors = 0;
  // Model: cycles since reset release, current levels, and the level captured for this frame.
  int m_c = 0;
  int m_lvl[NLeds];
  int m_sh[NLeds];
  int acc[NLeds];
  int last_duty[NLeds];

  typedef struct {
    logic [15:0] pattern;
    logic [7:0]  brightness;
    int          duty;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, m_c);
    end
  endtask

  // Check the current cycle, apply inputs for it, advance the model, move to the next cycle.
  task automatic cyc(input logic r, input logic [15:0] p, input logic [7:0] b);
    int slot;
    logic [15:0] exp_leds;
    slot = m_c % Frame;
    for (int i = 0; i < NLeds; i++) exp_leds[i] = (slot < m_sh[i]);
    check("o_leds", int'(leds), int'(exp_leds));
    check("o_frame", int'(frame), int'(m_c != 0 && slot == 0));
    for (int i = 0; i < NLeds; i++) begin
      if (frame) begin
        last_duty[i] = acc[i];
        acc[i] = 0;
      end
      acc[i] += int'(leds[i]);
    end
    rst = r; pat = p; bri = b;
    if (r) begin
      m_c = 0;
      for (int i = 0; i < NLeds; i++) begin m_lvl[i] = 0; m_sh[i] = 0; acc[i] = 0; end
    end else begin
      if (slot == Frame - 1) for (int i = 0; i < NLeds; i++) m_sh[i] = m_lvl[i];
      for (int i = 0; i < NLeds; i++) begin
        if (p[i]) m_lvl[i] = int'(b);
        else if (m_c % DecayDiv == DecayDiv - 1) m_lvl[i] = (m_lvl[i] > DecayStep) ?
                                                         m_lvl[i] - DecayStep : 0;
      end
      m_c++;
    end
    @(negedge clk);
  endtask

  task automatic run_to_frame(input logic [15:0] p, input logic [7:0] b);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      seen = frame;
      cyc(1'b0, p, b);
    end
    check("frame_seen", int'(seen), 1);
  endtask

  task automatic run_to_slot(input int s, input logic [15:0] p, input logic [7:0] b);
    for (int k = 0; k < 300 && (m_c % Frame) != s; k++) cyc(1'b0, p, b);
    check("slot_reached", m_c % Frame, s);
  endtask

  // Called in the first cycle after reset; expects the first o_frame 256 cycles later.
  task automatic first_frame(input string name, input logic [15:0] p, input logic [7:0] b);
    int hit = -1;
    for (int k = 0; k < 300 && hit < 0; k++) begin
      if (frame) hit = k;
      cyc(1'b0, p, b);
    end
    check(name, hit, 256);
    for (int i = 0; i < NLeds; i++) check("dark_first_frame", last_duty[i], 0);
  endtask

  initial begin
    vec_t vecs[5];
    int hit;
    logic [15:0] rp;
    logic [7:0]  rb;
    vecs[0] = '{16'hFFFF, 8'd128, 128};
    vecs[1] = '{16'hFFFF, 8'd255, 255};
    vecs[2] = '{16'hFFFF, 8'd0, 0};
    vecs[3] = '{16'h00F0, 8'd77, 77};
    vecs[4] = '{16'h8001, 8'd1, 1};
    for (int i = 0; i < NLeds; i++) begin
      m_lvl[i] = 0; m_sh[i] = 0; acc[i] = 0; last_duty[i] = 0;
    end

    // Reset held 3 cycles with everything requested on.
    rst = 1'b1; pat = 16'hFFFF; bri = 8'd200;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_leds", int'(leds), 0);
      check("rst_frame", int'(frame), 0);
      cyc(1'b1, 16'hFFFF, 8'd200);
    end
    first_frame("first_frame_at", 16'hFFFF, 8'd200);

    // Steady brightness table.
    foreach (vecs[v]) begin
      for (int f = 0; f < 3; f++) run_to_frame(vecs[v].pattern, vecs[v].brightness);
      for (int i = 0; i < NLeds; i++)
        check("steady_duty", last_duty[i], vecs[v].pattern[i] ? vecs[v].duty : 0);
    end

    // Decay trail: drop at slot 249; boundary captures 136, then 0 a frame later.
    run_to_frame(16'h0001, 8'd200);
    run_to_slot(249, 16'h0001, 8'd200);
    run_to_frame(16'h0000, 8'd200);
    check("decay_duty_held", last_duty[0], 200);
    run_to_frame(16'h0000, 8'd200);
    check("decay_duty_136", last_duty[0], 136);
    for (int i = 1; i < NLeds; i++) check("decay_others_dark", last_duty[i], 0);
    run_to_frame(16'h0000, 8'd200);
    check("decay_duty_0", last_duty[0], 0);

    // Attack on a tick cycle (slot 251) for one cycle: no decrement that cycle.
    run_to_slot(251, 16'h0000, 8'd200);
    cyc(1'b0, 16'h0020, 8'd200);
    run_to_frame(16'h0000, 8'd200);
    run_to_frame(16'h0000, 8'd200);
    check("attack_over_tick", last_duty[5], 200);
    run_to_frame(16'h0020, 8'd200);
    run_to_frame(16'h0020, 8'd50);
    run_to_frame(16'h0020, 8'd50);
    check("attack_track_bri", last_duty[5], 50);

    // Raise LED 3 exactly at slot 255: that frame misses it.
    for (int f = 0; f < 2; f++) run_to_frame(16'h0000, 8'd150);
    run_to_slot(255, 16'h0000, 8'd150);
    cyc(1'b0, 16'h0008, 8'd150);
    hit = -1;
    for (int k = 1; k <= 600 && hit < 0; k++) begin
      if (leds[3]) hit = k;
      cyc(1'b0, 16'h0008, 8'd150);
    end
    check("boundary_latency", hit, 257);
    check("boundary_missed_frame", last_duty[3], 0);
    run_to_frame(16'h0008, 8'd150);
    check("boundary_next_frame", last_duty[3], 150);

    // Mid-frame reset at slot 100 with all LEDs at 200.
    for (int f = 0; f < 2; f++) run_to_frame(16'hFFFF, 8'd200);
    run_to_slot(100, 16'hFFFF, 8'd200);
    cyc(1'b1, 16'hFFFF, 8'd200);
    check("midrst_leds", int'(leds), 0);
    check("midrst_frame", int'(frame), 0);
    first_frame("midrst_first_frame", 16'h0000, 8'd200);

    // Randomized traffic against the model.
    rp = 16'h0000; rb = 8'd0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(15) == 0) rp = 16'($urandom);
      if ($urandom_range(31) == 0) rb = 8'($urandom);
      cyc(($urandom_range(999) == 0), rp, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
